// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the shared memory-address port (A = fetch, B = load/store).
// Optional build macro ARB_FIXED_PRIO_EN: A wins ties; the hold limit still bounds B's wait.
module mem_port_arbiter #(
  parameter int SIZE     = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_a_i,
  input  logic            req_b_i,
  input  logic [SIZE-1:0] addr_a_i,
  input  logic [SIZE-1:0] addr_b_i,
  input  logic            done_i,
  output logic            gnt_a_o,
  output logic            gnt_b_o,
  output logic            sel_o,
  output logic [SIZE-1:0] addr_out_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  localparam int CNT_W = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic             last_b_q, last_b_d;   // 1: B was the most recent owner
  logic [CNT_W-1:0] hold_q, hold_d;

  logic tie_to_a;
  logic hold_max;
  logic forced_a, forced_b;
  logic keep_a;

  assign hold_max = (hold_q == HOLD_LIM);
  assign forced_a = req_b_i && hold_max;
  assign forced_b = req_a_i && hold_max;

`ifdef ARB_FIXED_PRIO_EN
  assign tie_to_a = 1'b1;
  // A keeps the port after DONE while B waits, but the hold counter keeps running so B still gets in.
  assign keep_a   = req_a_i && !forced_a;
`else
  assign tie_to_a = last_b_q;
  assign keep_a   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    hold_d   = hold_q;
    case (state_q)
      IDLE: begin
        if (req_a_i && (!req_b_i || tie_to_a)) begin
          state_d  = OWN_A;
          last_b_d = 1'b0;
          hold_d   = '0;
        end else if (req_b_i) begin
          state_d  = OWN_B;
          last_b_d = 1'b1;
          hold_d   = '0;
        end
      end
      OWN_A: begin
        if (done_i || !req_a_i || forced_a) begin
          if (req_b_i && !keep_a) begin
            state_d  = OWN_B;
            last_b_d = 1'b1;
            hold_d   = '0;
          end else if (req_a_i) begin
            last_b_d = 1'b0;
            hold_d   = (req_b_i) ? hold_q + 1'b1 : '0;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end else begin
          hold_d = hold_max ? hold_q : hold_q + 1'b1;
        end
      end
      OWN_B: begin
        if (done_i || !req_b_i || forced_b) begin
          if (req_a_i) begin
            state_d  = OWN_A;
            last_b_d = 1'b0;
            hold_d   = '0;
          end else if (req_b_i) begin
            last_b_d = 1'b1;
            hold_d   = '0;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end else begin
          hold_d = hold_max ? hold_q : hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      hold_q   <= hold_d;
    end
  end

  assign gnt_a_o = (state_q == OWN_A);
  assign gnt_b_o = (state_q == OWN_B);
  assign sel_o   = gnt_b_o;
  assign busy_o  = gnt_a_o | gnt_b_o;

  Scale_Mux #(.SIZE(SIZE)) u_mux (
    .sel_i (sel_o),
    .a_i   (addr_a_i),
    .b_i   (addr_b_i),
    .out_o (addr_out_o)
  );

endmodule

// 2:1 address mux; selects B when sel_i is high.
module Scale_Mux #(
  parameter int SIZE = 8
) (
  input  logic            sel_i,
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_i,
  output logic [SIZE-1:0] out_o
);
  assign out_o = sel_i ? b_i : a_i;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter: the driver queues hand-computed expectations,
// a monitor pops one per clock edge and compares grants, select, busy and the muxed address.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst, req_a, req_b, done;
  logic [7:0] addr_a, addr_b;
  logic       gnt_a, gnt_b, sel, busy;
  logic [7:0] addr_out;

  typedef struct {
    int         idx;
    logic       ga;
    logic       gb;
    logic [7:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   vec_n = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.SIZE(8), .MAX_HOLD(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_a_i    (req_a),
    .req_b_i    (req_b),
    .addr_a_i   (addr_a),
    .addr_b_i   (addr_b),
    .done_i     (done),
    .gnt_a_o    (gnt_a),
    .gnt_b_o    (gnt_b),
    .sel_o      (sel),
    .addr_out_o (addr_out),
    .busy_o     (busy)
  );

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL vec%0d %s: got %h want %h", idx, name, act, req);
    end
  endtask

  // Monitor: one expectation per clock edge once the driver has queued it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("gnt_a", e.idx, {7'd0, gnt_a}, {7'd0, e.ga});
      check("gnt_b", e.idx, {7'd0, gnt_b}, {7'd0, e.gb});
      check("sel", e.idx, {7'd0, sel}, {7'd0, e.gb});
      check("busy", e.idx, {7'd0, busy}, {7'd0, e.ga | e.gb});
      check("onehot", e.idx, {7'd0, gnt_a & gnt_b}, 8'd0);
      check("addr_out", e.idx, addr_out, e.addr);
      $display("vec%0d rst=%0b ra=%0b rb=%0b dn=%0b -> ga=%0b gb=%0b addr=%h",
               e.idx, rst, req_a, req_b, done, gnt_a, gnt_b, addr_out);
    end
  end

  task automatic drive(input logic r, input logic ra, input logic rb, input logic dn,
                       input logic [7:0] aa, input logic [7:0] ab,
                       input logic ega, input logic egb);
    exp_t e;
    @(negedge clk);
    rst = r; req_a = ra; req_b = rb; done = dn; addr_a = aa; addr_b = ab;
    e.idx  = vec_n;
    e.ga   = ega;
    e.gb   = egb;
    e.addr = egb ? ab : aa;
    exp_q.push_back(e);
    vec_n++;
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; done = 1'b0; addr_a = 8'h00; addr_b = 8'h00;
    // Reset held with both requesting, then the first tie goes to A.
    drive(1, 1, 1, 0, 8'h11, 8'h22, 0, 0);
    drive(1, 1, 1, 0, 8'h11, 8'h22, 0, 0);
    // Contention with MAX_HOLD=4: A x4, B x4, A.
    drive(0, 1, 1, 0, 8'h11, 8'h22, 1, 0);
    drive(0, 1, 1, 0, 8'h11, 8'h22, 1, 0);
    drive(0, 1, 1, 0, 8'h11, 8'h22, 1, 0);
    drive(0, 1, 1, 0, 8'h11, 8'h22, 1, 0);
    drive(0, 1, 1, 0, 8'h11, 8'h22, 0, 1);
    drive(0, 1, 1, 0, 8'h11, 8'h22, 0, 1);
    drive(0, 1, 1, 0, 8'h11, 8'h22, 0, 1);
    drive(0, 1, 1, 0, 8'h11, 8'h22, 0, 1);
    drive(0, 1, 1, 0, 8'h11, 8'h22, 1, 0);
    // DONE in OWN_A with B waiting: direct hand-off.
    drive(0, 1, 1, 1, 8'h11, 8'h22, 0, 1);
    drive(0, 0, 1, 0, 8'h11, 8'h22, 0, 1);
    drive(0, 0, 0, 0, 8'h11, 8'h22, 0, 0);
    // Single requester B at 0x3C for two cycles, released with DONE.
    drive(0, 0, 1, 0, 8'h55, 8'h3C, 0, 1);
    drive(0, 0, 1, 0, 8'h55, 8'h3C, 0, 1);
    drive(0, 0, 0, 1, 8'h55, 8'h3C, 0, 0);
    drive(0, 0, 0, 1, 8'h55, 8'h3C, 0, 0);
    // Single A, re-grant after DONE, then a tie goes to B since A was last.
    drive(0, 1, 0, 0, 8'hA5, 8'h5A, 1, 0);
    drive(0, 1, 0, 1, 8'hA5, 8'h5A, 1, 0);
    drive(0, 0, 0, 0, 8'hA5, 8'h5A, 0, 0);
    drive(0, 1, 1, 0, 8'hA5, 8'h5A, 0, 1);
    drive(0, 0, 0, 0, 8'hA5, 8'h5A, 0, 0);
    // A alone saturates its hold counter, then B arrives and forces release at once.
    drive(0, 1, 0, 0, 8'h0F, 8'hF0, 1, 0);
    drive(0, 1, 0, 0, 8'h0F, 8'hF0, 1, 0);
    drive(0, 1, 0, 0, 8'h0F, 8'hF0, 1, 0);
    drive(0, 1, 0, 0, 8'h0F, 8'hF0, 1, 0);
    drive(0, 1, 0, 0, 8'h0F, 8'hF0, 1, 0);
    drive(0, 1, 1, 0, 8'h0F, 8'hF0, 0, 1);
    // B held to hold count 2, reset mid-grant, first tie afterwards to A.
    drive(0, 1, 1, 0, 8'h0F, 8'hF0, 0, 1);
    drive(0, 1, 1, 0, 8'h0F, 8'hF0, 0, 1);
    drive(1, 1, 1, 0, 8'h0F, 8'hF0, 0, 0);
    drive(0, 1, 1, 0, 8'h0F, 8'hF0, 1, 0);
    drive(0, 0, 0, 0, 8'h0F, 8'hF0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
